// File: rtl/pipe_cu_pkg.sv
// pipe_cu_pkg: shared definitions for the pipeline hazard control unit.
//   instr_type_e           - control-flow class of an opcode (B, J, OTHER)
//   OPC_*                  - RV32 major opcodes the unit cares about
//   FETCH_SEL_*            - fetch mux select encodings (match defines.vh)
//   get_instruction_type() - classify a 7-bit opcode
package pipe_cu_pkg;

  typedef enum logic [1:0] {
    INSTR_B     = 2'd0,
    INSTR_J     = 2'd1,
    INSTR_OTHER = 2'd2
  } instr_type_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [1:0] FETCH_SEL_PC     = 2'b00;
  localparam logic [1:0] FETCH_SEL_NOP    = 2'b01;
  localparam logic [1:0] FETCH_SEL_BRANCH = 2'b10;

  function automatic instr_type_e get_instruction_type(input logic [6:0] opc);
    instr_type_e t;
    case (opc)
      OPC_BRANCH:         t = INSTR_B;
      OPC_JAL, OPC_JALR:  t = INSTR_J;
      default:            t = INSTR_OTHER;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cu_sat_cnt.sv
// cu_sat_cnt: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk     - core clock
//   rst_n   - asynchronous active-low reset (count -> 0)
//   inc_i   - increment enable for this cycle
//   count_o - current count
module cu_sat_cnt
  import pipe_cu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_cu.sv
// pipe_hazard_cu: control-flow / load-use hazard unit for the in-order core.
// Tracks each branch/jump from fetch until EX resolves it, holding the PC and
// bubbling fetch meanwhile, then redirects on a taken outcome.
//   clk, rst_n          - clock, asynchronous active-low reset
//   fetch_valid         - fetch holds a valid instruction
//   opcode_fetch/_dec   - opcodes in fetch and decode
//   rd_dec, rs1/rs2_fetch - register ids for load-use detection
//   resolve_valid       - one-cycle resolution pulse from EX
//   branch_taken        - resolution outcome
//   pipe_flush          - trap flush, overrides everything
//   fetch_sel           - FETCH_SEL_PC / _NOP (hold) / _BRANCH
//   nop_output_fetch    - fetch emits a bubble
//   nop_output_dec      - decode emits a bubble into EX (load-use)
//   cf_error            - sticky protocol error
//   cf_count, bubble_count - saturating performance counters
// Build option: define CU_LOAD_USE_EN to enable the load-use interlock;
// otherwise nop_output_dec is 0 and the register-id ports are ignored.
module pipe_hazard_cu
  import pipe_cu_pkg::*;
#(
  parameter int unsigned RESOLVE_DEPTH = 2,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_valid,
  input  logic [6:0]         opcode_fetch,
  input  logic [6:0]         opcode_dec,
  input  logic [4:0]         rd_dec,
  input  logic [4:0]         rs1_fetch,
  input  logic [4:0]         rs2_fetch,
  input  logic               resolve_valid,
  input  logic               branch_taken,
  input  logic               pipe_flush,
  output logic [1:0]         fetch_sel,
  output logic               nop_output_fetch,
  output logic               nop_output_dec,
  output logic               cf_error,
  output logic [COUNT_W-1:0] cf_count,
  output logic [COUNT_W-1:0] bubble_count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [2:0] DEPTH_L = 3'(RESOLVE_DEPTH);

  logic [0:0]  state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        cf_error_q, cf_error_d;
  logic        lu_done_q, lu_done_d;

  logic        cf_inc, bubble_inc;
  logic [1:0]  fetch_sel_c;
  logic        nop_fetch_c, nop_dec_c;
  logic        fetch_is_cf;
  logic        load_use;
  instr_type_e fetch_type;

  assign fetch_type  = get_instruction_type(opcode_fetch);
  assign fetch_is_cf = fetch_valid && (fetch_type != INSTR_OTHER);

`ifdef CU_LOAD_USE_EN
  // lu_done_q limits the interlock to one cycle even if decode still shows
  // the load, so a stalled branch enters WAIT on the very next cycle.
  assign load_use = (state_q == S_IDLE) && fetch_valid && !lu_done_q &&
                    (opcode_dec == OPC_LOAD) && (rd_dec != 5'd0) &&
                    ((rd_dec == rs1_fetch) || (rd_dec == rs2_fetch));
`else
  logic unused_lu;
  assign load_use  = 1'b0;
  assign unused_lu = ^{opcode_dec, rd_dec, rs1_fetch, rs2_fetch, lu_done_q};
`endif

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cf_error_d  = cf_error_q;
    lu_done_d   = 1'b0;
    fetch_sel_c = FETCH_SEL_PC;
    nop_fetch_c = 1'b0;
    nop_dec_c   = 1'b0;
    cf_inc      = 1'b0;
    bubble_inc  = 1'b0;

    if (pipe_flush) begin
      // Trap flush drops any pending resolution; it is neither counted as a
      // transfer nor as a hazard bubble.
      state_d     = S_IDLE;
      wait_cnt_d  = 3'd0;
      fetch_sel_c = FETCH_SEL_NOP;
      nop_fetch_c = 1'b1;
    end else if (state_q == S_IDLE) begin
      if (resolve_valid) begin
        cf_error_d = 1'b1;  // nothing outstanding: stray pulse
      end
      if (load_use) begin
        fetch_sel_c = FETCH_SEL_NOP;
        nop_dec_c   = 1'b1;
        bubble_inc  = 1'b1;
        lu_done_d   = 1'b1;
      end else if (fetch_is_cf) begin
        // The branch itself proceeds; only what follows it is held.
        fetch_sel_c = FETCH_SEL_NOP;
        wait_cnt_d  = 3'd0;
        state_d     = S_WAIT;
      end
    end else begin
      nop_fetch_c = 1'b1;
      bubble_inc  = 1'b1;
      if (resolve_valid) begin
        fetch_sel_c = branch_taken ? FETCH_SEL_BRANCH : FETCH_SEL_PC;
        cf_inc      = 1'b1;
        state_d     = S_IDLE;
      end else begin
        fetch_sel_c = FETCH_SEL_NOP;
        if (wait_cnt_q != 3'd7) begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
        // Flag on the edge where the count would pass RESOLVE_DEPTH.
        if (wait_cnt_q == DEPTH_L) begin
          cf_error_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 3'd0;
      cf_error_q <= 1'b0;
      lu_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cf_error_q <= cf_error_d;
      lu_done_q  <= lu_done_d;
    end
  end

  cu_sat_cnt #(.W(COUNT_W)) u_cf_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (cf_inc),
    .count_o (cf_count)
  );

  cu_sat_cnt #(.W(COUNT_W)) u_bubble_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (bubble_inc),
    .count_o (bubble_count)
  );

  // Outputs are forced to their idle values while reset is held, even if
  // fetch is presenting a branch.
  assign fetch_sel        = rst_n ? fetch_sel_c : FETCH_SEL_PC;
  assign nop_output_fetch = rst_n & nop_fetch_c;
  assign nop_output_dec   = rst_n & nop_dec_c;
  assign cf_error         = cf_error_q;

endmodule

// File: tb/tb_pipe_hazard_cu.sv
module tb_pipe_hazard_cu;

  localparam int DEPTH = 2;
  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_NOP = 2'd1;
  localparam logic [1:0] SEL_BR  = 2'd2;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
`ifdef CU_LOAD_USE_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_valid = 1'b0;
  logic [6:0] opcode_fetch = OP_ADD;
  logic [6:0] opcode_dec = OP_ADD;
  logic [4:0] rd_dec = 5'd0, rs1_fetch = 5'd0, rs2_fetch = 5'd0;
  logic resolve_valid = 1'b0, branch_taken = 1'b0, pipe_flush = 1'b0;

  logic [1:0]  fetch_sel, fetch_sel_s;
  logic        nop_f, nop_d, err, nop_f_s, nop_d_s, err_s;
  logic [15:0] cf_cnt, bub_cnt;
  logic [3:0]  cf_cnt_s, bub_cnt_s;

  pipe_hazard_cu #(.RESOLVE_DEPTH(DEPTH), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid),
    .opcode_fetch(opcode_fetch), .opcode_dec(opcode_dec), .rd_dec(rd_dec),
    .rs1_fetch(rs1_fetch), .rs2_fetch(rs2_fetch),
    .resolve_valid(resolve_valid), .branch_taken(branch_taken),
    .pipe_flush(pipe_flush), .fetch_sel(fetch_sel),
    .nop_output_fetch(nop_f), .nop_output_dec(nop_d), .cf_error(err),
    .cf_count(cf_cnt), .bubble_count(bub_cnt)
  );

  // Narrow-counter copy on the same stimulus, for saturation checks.
  pipe_hazard_cu #(.RESOLVE_DEPTH(DEPTH), .COUNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid),
    .opcode_fetch(opcode_fetch), .opcode_dec(opcode_dec), .rd_dec(rd_dec),
    .rs1_fetch(rs1_fetch), .rs2_fetch(rs2_fetch),
    .resolve_valid(resolve_valid), .branch_taken(branch_taken),
    .pipe_flush(pipe_flush), .fetch_sel(fetch_sel_s),
    .nop_output_fetch(nop_f_s), .nop_output_dec(nop_d_s), .cf_error(err_s),
    .cf_count(cf_cnt_s), .bubble_count(bub_cnt_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: "waiting" flag, cycles spent waiting, unbounded counts.
  bit m_wait, m_err, m_lu_prev;
  int m_age, m_cf, m_bub;

  task automatic model_reset();
    m_wait = 0; m_err = 0; m_lu_prev = 0; m_age = 0; m_cf = 0; m_bub = 0;
  endtask

  task automatic model_cycle(output logic [1:0] esel, output logic enf, output logic endc);
    bit is_cf, stall;
    is_cf = fetch_valid && (opcode_fetch == OP_BEQ || opcode_fetch == OP_JAL ||
                            opcode_fetch == OP_JALR);
    stall = LU_EN && !m_wait && !m_lu_prev && fetch_valid && opcode_dec == OP_LW &&
            rd_dec != 0 && (rd_dec == rs1_fetch || rd_dec == rs2_fetch);
    esel = SEL_PC; enf = 0; endc = 0;
    if (pipe_flush) begin
      esel = SEL_NOP; enf = 1; m_wait = 0; m_lu_prev = 0;
    end else if (!m_wait) begin
      m_lu_prev = 0;
      if (resolve_valid) m_err = 1;
      if (stall) begin
        esel = SEL_NOP; endc = 1; m_bub++; m_lu_prev = 1;
      end else if (is_cf) begin
        esel = SEL_NOP; m_wait = 1; m_age = 0;
      end
    end else begin
      enf = 1; m_bub++; m_lu_prev = 0;
      if (resolve_valid) begin
        esel = branch_taken ? SEL_BR : SEL_PC; m_cf++; m_wait = 0;
      end else begin
        esel = SEL_NOP; m_age++;
        if (m_age == DEPTH + 1) m_err = 1;
      end
    end
  endtask

  task automatic drv(input logic fv, input logic [6:0] op, input logic rv,
                     input logic tk, input logic fl);
    fetch_valid = fv; opcode_fetch = op; resolve_valid = rv;
    branch_taken = tk; pipe_flush = fl;
  endtask

  task automatic do_reset();
    drv(0, OP_ADD, 0, 0, 0);
    opcode_dec = OP_ADD; rd_dec = 0; rs1_fetch = 0; rs2_fetch = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       fv;
    logic [6:0] op;
    logic       rv;
    logic       tk;
    logic [1:0] e_sel;
    logic       e_nf;
    logic       e_err;
    int         e_cf;
    int         e_bub;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [1:0] esel;
    logic enf, endc;

    vecs[0]  = '{0, OP_ADD,  0, 0, SEL_PC,  0, 0, 0, 0};
    vecs[1]  = '{1, OP_BEQ,  0, 0, SEL_NOP, 0, 0, 0, 0};  // T
    vecs[2]  = '{1, OP_ADD,  0, 0, SEL_NOP, 1, 0, 0, 0};  // T+1
    vecs[3]  = '{1, OP_ADD,  1, 1, SEL_BR,  1, 0, 0, 1};  // T+2 taken
    vecs[4]  = '{0, OP_ADD,  0, 0, SEL_PC,  0, 0, 1, 2};
    vecs[5]  = '{1, OP_JAL,  0, 0, SEL_NOP, 0, 0, 1, 2};
    vecs[6]  = '{0, OP_ADD,  0, 0, SEL_NOP, 1, 0, 1, 2};
    vecs[7]  = '{0, OP_ADD,  1, 0, SEL_PC,  1, 0, 1, 3};  // not taken
    vecs[8]  = '{0, OP_ADD,  0, 0, SEL_PC,  0, 0, 2, 4};  // back in IDLE
    vecs[9]  = '{1, OP_BEQ,  0, 0, SEL_NOP, 0, 0, 2, 4};
    vecs[10] = '{0, OP_ADD,  0, 0, SEL_NOP, 1, 0, 2, 4};
    vecs[11] = '{1, OP_JALR, 1, 1, SEL_BR,  1, 0, 2, 5};
    vecs[12] = '{1, OP_JALR, 0, 0, SEL_NOP, 0, 0, 3, 6};  // back-to-back
    vecs[13] = '{0, OP_ADD,  0, 0, SEL_NOP, 1, 0, 3, 6};
    vecs[14] = '{0, OP_ADD,  1, 0, SEL_PC,  1, 0, 3, 7};
    vecs[15] = '{0, OP_ADD,  1, 0, SEL_PC,  0, 0, 4, 8};  // stray pulse
    vecs[16] = '{0, OP_ADD,  0, 0, SEL_PC,  0, 1, 4, 8};

    // ---------------- table-driven nominal sequences ----------------
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drv(vecs[i].fv, vecs[i].op, vecs[i].rv, vecs[i].tk, 0);
      #1;
      chk($sformatf("vec%0d.fetch_sel", i), 32'(fetch_sel), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d.nop_fetch", i), 32'(nop_f), 32'(vecs[i].e_nf));
      chk($sformatf("vec%0d.nop_dec", i), 32'(nop_d), 32'd0);
      chk($sformatf("vec%0d.cf_error", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d.cf_count", i), 32'(cf_cnt), 32'(vecs[i].e_cf));
      chk($sformatf("vec%0d.bubble_count", i), 32'(bub_cnt), 32'(vecs[i].e_bub));
      $display("vec %0d: fv=%0b op=%b rv=%0b tk=%0b -> sel=%0d nf=%0b err=%0b cf=%0d bub=%0d",
               i, vecs[i].fv, vecs[i].op, vecs[i].rv, vecs[i].tk,
               fetch_sel, nop_f, err, cf_cnt, bub_cnt);
      @(negedge clk);
    end

    // ---------------- timeout without resolve, then flush ----------------
    do_reset();
    drv(1, OP_BEQ, 0, 0, 0); #1;
    chk("to.T.sel", 32'(fetch_sel), 32'(SEL_NOP));
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      drv(0, OP_ADD, 0, 0, 0); #1;
      chk($sformatf("to.T+%0d.err", k), 32'(err), 32'd0);
      chk($sformatf("to.T+%0d.sel", k), 32'(fetch_sel), 32'(SEL_NOP));
      @(negedge clk);
    end
    #1; chk("to.T+4.err", 32'(err), 32'd1);
    @(negedge clk);
    drv(0, OP_ADD, 0, 0, 1); #1;
    chk("to.flush.sel", 32'(fetch_sel), 32'(SEL_NOP));
    chk("to.flush.nf", 32'(nop_f), 32'd1);
    chk("to.flush.err", 32'(err), 32'd1);
    @(negedge clk);
    drv(1, OP_ADD, 0, 0, 0); #1;
    chk("to.idle.sel", 32'(fetch_sel), 32'(SEL_PC));
    chk("to.idle.nf", 32'(nop_f), 32'd0);
    chk("to.idle.err", 32'(err), 32'd1);
    $display("timeout sequence: err=%0b sel=%0d", err, fetch_sel);
    @(negedge clk);
    drv(1, OP_BEQ, 0, 0, 0); #1;
    chk("to.rearm.sel", 32'(fetch_sel), 32'(SEL_NOP));
    chk("to.rearm.nf", 32'(nop_f), 32'd0);
    @(negedge clk);

    // ---------------- asynchronous reset mid-WAIT ----------------
    do_reset();
    drv(1, OP_BEQ, 0, 0, 0);
    @(negedge clk);
    drv(0, OP_ADD, 0, 0, 0);
    @(negedge clk);
    #1; chk("rst.wait.nf", 32'(nop_f), 32'd1);
    chk("rst.wait.bub", 32'(bub_cnt), 32'd1);
    #1; rst_n = 1'b0; #1;
    chk("rst.sel", 32'(fetch_sel), 32'(SEL_PC));
    chk("rst.nf", 32'(nop_f), 32'd0);
    chk("rst.nd", 32'(nop_d), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.cf", 32'(cf_cnt), 32'd0);
    chk("rst.bub", 32'(bub_cnt), 32'd0);
    $display("async reset mid-WAIT: sel=%0d nf=%0b bub=%0d", fetch_sel, nop_f, bub_cnt);
    @(negedge clk);

    // ---------------- counter saturation ----------------
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drv(1, OP_BEQ, 0, 0, 0); @(negedge clk);
      drv(0, OP_ADD, 0, 0, 0); @(negedge clk);
      drv(0, OP_ADD, 1, k[0], 0); @(negedge clk);
    end
    drv(0, OP_ADD, 0, 0, 0); #1;
    chk("sat4.cf", 32'(cf_cnt_s), 32'd15);
    chk("sat4.bub", 32'(bub_cnt_s), 32'd15);
    chk("w16.cf", 32'(cf_cnt), 32'd20);
    chk("w16.bub", 32'(bub_cnt), 32'd40);
    chk("sat.err", 32'(err), 32'd0);
    $display("saturation: cf4=%0d bub4=%0d cf16=%0d bub16=%0d",
             cf_cnt_s, bub_cnt_s, cf_cnt, bub_cnt);
    @(negedge clk);

    // ---------------- load-use interlock ----------------
    do_reset();
    opcode_dec = OP_LW; rd_dec = 5'd5; rs1_fetch = 5'd5; rs2_fetch = 5'd1;
    drv(1, OP_ADD, 0, 0, 0); #1;
`ifdef CU_LOAD_USE_EN
    chk("lu.nd", 32'(nop_d), 32'd1);
    chk("lu.sel", 32'(fetch_sel), 32'(SEL_NOP));
    chk("lu.nf", 32'(nop_f), 32'd0);
    @(negedge clk); #1;
    chk("lu.next.nd", 32'(nop_d), 32'd0);
    chk("lu.next.sel", 32'(fetch_sel), 32'(SEL_PC));
    chk("lu.bub", 32'(bub_cnt), 32'd1);
    @(negedge clk);
    rd_dec = 5'd0; rs1_fetch = 5'd0; #1;
    chk("lu.x0.nd", 32'(nop_d), 32'd0);
    chk("lu.x0.sel", 32'(fetch_sel), 32'(SEL_PC));
    @(negedge clk);
    rd_dec = 5'd7; rs1_fetch = 5'd2; rs2_fetch = 5'd7;
    drv(1, OP_BEQ, 0, 0, 0); #1;
    chk("lu.br.nd", 32'(nop_d), 32'd1);
    @(negedge clk); #1;
    chk("lu.br2.nd", 32'(nop_d), 32'd0);
    chk("lu.br2.sel", 32'(fetch_sel), 32'(SEL_NOP));
    chk("lu.br2.nf", 32'(nop_f), 32'd0);
    @(negedge clk);
    drv(0, OP_ADD, 0, 0, 0); #1;
    chk("lu.br3.nf", 32'(nop_f), 32'd1);
`else
    chk("lu.off.nd", 32'(nop_d), 32'd0);
    chk("lu.off.sel", 32'(fetch_sel), 32'(SEL_PC));
`endif
    $display("load-use: nd=%0b sel=%0d", nop_d, fetch_sel);
    @(negedge clk);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [6:0] op;
      logic fl, rv;
      case ($urandom_range(0, 5))
        0: op = OP_BEQ;
        1: op = OP_JAL;
        2: op = OP_JALR;
        3: op = OP_LW;
        4: op = OP_ADD;
        default: op = 7'($urandom);
      endcase
      fl = ($urandom_range(0, 49) == 0);
      if (m_wait) rv = (m_age == DEPTH - 1) ? ($urandom_range(0, 9) < 8)
                                            : ($urandom_range(0, 9) == 0);
      else        rv = ($urandom_range(0, 39) == 0);
      if (fl) rv = 1'b0;
      drv(1'($urandom), op, rv, 1'($urandom), fl);
      opcode_dec = ($urandom_range(0, 2) == 0) ? OP_LW : OP_ADD;
      rd_dec    = 5'($urandom_range(0, 3));
      rs1_fetch = 5'($urandom_range(0, 3));
      rs2_fetch = 5'($urandom_range(0, 3));
      #1;
      chk("rnd.err", 32'(err), 32'(m_err));
      chk("rnd.cf", 32'(cf_cnt), 32'(sat(m_cf, 16)));
      chk("rnd.bub", 32'(bub_cnt), 32'(sat(m_bub, 16)));
      chk("rnd.cf4", 32'(cf_cnt_s), 32'(sat(m_cf, 4)));
      chk("rnd.bub4", 32'(bub_cnt_s), 32'(sat(m_bub, 4)));
      chk("rnd.err4", 32'(err_s), 32'(m_err));
      model_cycle(esel, enf, endc);
      chk("rnd.sel", 32'(fetch_sel), 32'(esel));
      chk("rnd.nf", 32'(nop_f), 32'(enf));
      chk("rnd.nd", 32'(nop_d), 32'(endc));
      chk("rnd.sel4", 32'(fetch_sel_s), 32'(esel));
      chk("rnd.nf4", 32'(nop_f_s), 32'(enf));
      chk("rnd.nd4", 32'(nop_d_s), 32'(endc));
      $display("rnd %0d: fv=%0b op=%b rv=%0b fl=%0b -> sel=%0d nf=%0b nd=%0b cf=%0d bub=%0d",
               c, fetch_valid, opcode_fetch, resolve_valid, pipe_flush,
               fetch_sel, nop_f, nop_d, cf_cnt, bub_cnt);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
